// File: rtl/sume_tx_if.sv
// Operand request bus into sume_tx: two NIBBLES-wide BCD/hex operands
// with a single valid/ready pair.
interface sume_tx_if #(
    parameter int NIBBLES = 3
);
    localparam int W = 4 * NIBBLES;

    // A transfer happens on a rising clk edge where req_valid && req_ready.
    // The source must hold op_a/op_b stable while req_valid is high and
    // req_ready is low; req_ready never depends on req_valid.
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         req_valid;
    logic         req_ready;

    modport master (
        output op_a,
        output op_b,
        output req_valid,
        input  req_ready
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  req_valid,
        output req_ready
    );
endinterface

// File: rtl/sume_tx.sv
// Nibble-serial transmitter for the sume summer: frames {op_a, op_b} MSB nibble
// first into a fixed 2*NIBBLES+1 slot frame. Optional BCD reject: SUME_TX_BCD_CHECK_EN.
module sume_tx #(
    parameter int NIBBLES = 3
) (
    input  logic       clk,
    input  logic       n_reset,
    sume_tx_if.slave   req,
    output logic [3:0] sample,
    output logic       frame,
    output logic       done,
    output logic       err_bcd
);
    localparam int W  = 4 * NIBBLES;
    localparam int SW = 2 * W;
    localparam int P  = 2 * NIBBLES + 1;
    localparam int CW = $clog2(P);

    localparam logic [CW-1:0] LAST_SLOT = CW'(P - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(P - 2);

    logic [CW-1:0] slot_q, slot_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] buf_q, buf_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          active_q, active_d;
    logic [3:0]    sample_q, sample_d;
    logic          frame_q, frame_d;
    logic          done_q, done_d;

    logic          xfer;
    logic          bcd_reject;

`ifdef SUME_TX_BCD_CHECK_EN
    logic          err_q, err_d;

    function automatic logic has_non_bcd(input logic [SW-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 2 * NIBBLES; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    assign bcd_reject = has_non_bcd({req.op_a, req.op_b});
    assign err_bcd    = err_q;
`else
    assign bcd_reject = 1'b0;
    assign err_bcd    = 1'b0;
`endif

    assign req.req_ready = !pend_q;
    assign xfer          = req.req_valid && !pend_q;

    assign sample = sample_q;
    assign frame  = frame_q;
    assign done   = done_q;

    always_comb begin
        slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + CW'(1);
        pend_d   = pend_q;
        buf_d    = buf_q;
        shift_d  = shift_q;
        active_d = active_q;
        sample_d = sample_q;
        frame_d  = 1'b0;
        done_d   = 1'b0;
`ifdef SUME_TX_BCD_CHECK_EN
        err_d    = xfer && bcd_reject;
`endif

        // sample/frame/done are registered, so each is computed one slot ahead.
        if (slot_q == LAST_SLOT) begin
            active_d = pend_q;
            frame_d  = pend_q;
            if (pend_q) begin
                sample_d = buf_q[SW-1 -: 4];
                shift_d  = {buf_q[SW-5:0], 4'h0};
                pend_d   = 1'b0;
            end else begin
                sample_d = 4'h0;
                shift_d  = '0;
            end
        end else if (slot_q == PRE_LAST) begin
            sample_d = 4'h0;
            done_d   = active_q;
        end else begin
            sample_d = shift_q[SW-1 -: 4];
            shift_d  = {shift_q[SW-5:0], 4'h0};
        end

        // A transfer needs pend_q==0, so it never collides with the load above.
        if (xfer && !bcd_reject) begin
            pend_d = 1'b1;
            buf_d  = {req.op_a, req.op_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            slot_q   <= '0;
            pend_q   <= 1'b0;
            buf_q    <= '0;
            shift_q  <= '0;
            active_q <= 1'b0;
            sample_q <= 4'h0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef SUME_TX_BCD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            slot_q   <= slot_d;
            pend_q   <= pend_d;
            buf_q    <= buf_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            sample_q <= sample_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
`ifdef SUME_TX_BCD_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_sume_tx.sv
// Bench for sume_tx: a per-cycle expectation timeline filled from accepted
// requests, compared every cycle, plus literal latency/data checks per scenario.
module tb_sume_tx;
    localparam int NIB = 3;
    localparam int W   = 4 * NIB;
    localparam int P   = 2 * NIB + 1;
    localparam int N   = 2048;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] sample;
    logic       frame;
    logic       done;
    logic       err_bcd;

    sume_tx_if #(.NIBBLES(NIB)) bus ();

    sume_tx #(.NIBBLES(NIB)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .req     (bus),
        .sample  (sample),
        .frame   (frame),
        .done    (done),
        .err_bcd (err_bcd)
    );

    always #5 clk = ~clk;

    int  cyc    = 0;
    int  base   = 0;
    int  errors = 0;
    int  checks = 0;
    bit  armed  = 1'b0;

    logic [3:0] exp_sample [N];
    bit         exp_frame  [N];
    bit         exp_done   [N];
    bit         exp_ready  [N];
    bit         exp_err    [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req_v);
        end
    endtask

    task automatic clear_from(input int from);
        for (int j = from; j < N; j++) begin
            exp_sample[j] = 4'h0;
            exp_frame[j]  = 1'b0;
            exp_done[j]   = 1'b0;
            exp_ready[j]  = 1'b1;
            exp_err[j]    = 1'b0;
        end
    endtask

`ifdef SUME_TX_BCD_CHECK_EN
    function automatic bit non_bcd(input logic [W-1:0] v);
        bit r;
        r = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            if (((v >> (4 * i)) & 12'hF) > 12'd9) r = 1'b1;
        end
        return r;
    endfunction
`endif

    // Frames start on multiples of P after reset release; a request accepted in
    // the last slot misses that boundary and takes the following one.
    task automatic model_accept(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        int st;
        logic [2*W-1:0] both;
        s = (c - base) % P;
`ifdef SUME_TX_BCD_CHECK_EN
        if (non_bcd(a) || non_bcd(b)) begin
            exp_err[c+1] = 1'b1;
            return;
        end
`endif
        st = c + (P - s);
        if (s == P - 1) st = st + P;
        both = {a, b};
        for (int j = c + 1; j < st; j++) exp_ready[j] = 1'b0;
        exp_frame[st]       = 1'b1;
        exp_done[st + P - 1] = 1'b1;
        for (int i = 0; i < 2 * NIB; i++) begin
            exp_sample[st + i] = 4'((both >> (4 * (2 * NIB - 1 - i))) & 24'hF);
        end
    endtask

    always @(negedge clk) begin
        int k;
        k = cyc;
        if (armed && k < N) begin
            chk("sample",    {28'h0, sample},  {28'h0, exp_sample[k]});
            chk("frame",     {31'h0, frame},   {31'h0, exp_frame[k]});
            chk("done",      {31'h0, done},    {31'h0, exp_done[k]});
            chk("req_ready", {31'h0, bus.req_ready}, {31'h0, exp_ready[k]});
            chk("err_bcd",   {31'h0, err_bcd}, {31'h0, exp_err[k]});
        end
        if (!n_reset) begin
            base  = k + 1;
            armed = 1'b1;
            clear_from(k + 1);
        end else if (armed && bus.req_valid && exp_ready[k]) begin
            model_accept(k, bus.op_a, bus.op_b);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int slot_now();
        return (cyc - base) % P;
    endfunction

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        next_cycle();
        while (slot_now() != s && n < 3 * P) begin
            next_cycle();
            n++;
        end
    endtask

    // Leaves req_valid high on return so a following push is back-to-back.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        int n;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.req_valid = 1'b1;
        n = 0;
        while (!exp_ready[cyc] && n < 4 * P) begin
            next_cycle();
            n++;
        end
        chk("push_accept", {31'h0, exp_ready[cyc]}, 32'h1);
        acc = cyc;
        next_cycle();
    endtask

    task automatic collect(input int acc, input int lat, input logic [27:0] vec_req, input string name);
        int n;
        logic [27:0] vec;
        n = 0;
        @(negedge clk);
        while (frame !== 1'b1 && n < 3 * P) begin
            @(negedge clk);
            n++;
        end
        if (frame !== 1'b1) begin
            chk({name, "_frame_timeout"}, 32'h0, 32'h1);
            return;
        end
        chk({name, "_latency"}, cyc - acc, lat);
        vec = '0;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            vec = {vec[23:0], sample};
        end
        chk({name, "_done"}, {31'h0, done}, 32'h1);
        chk({name, "_nibbles"}, {4'h0, vec}, {4'h0, vec_req});
    endtask

    task automatic watch(input int ncyc, output int nf, output int nd, output int ne);
        nf = 0;
        nd = 0;
        ne = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (frame === 1'b1) nf++;
            if (done === 1'b1) nd++;
            if (err_bcd === 1'b1) ne++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a1, a2, acc, nf, nd, ne;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.req_valid = 1'b0;
        clear_from(0);
        n_reset = 1'b0;
        repeat (3) next_cycle();
        n_reset = 1'b1;

        // idle after reset
        watch(2 * P, nf, nd, ne);
        chk("idle_frames", nf, 0);
        chk("idle_dones", nd, 0);

        // single request accepted in slot 2
        wait_slot(2);
        push(12'h123, 12'h456, acc);
        bus.req_valid = 1'b0;
        collect(acc, 5, 28'h1234560, "single");

        // two requests held valid back-to-back
        wait_slot(4);
        push(12'h987, 12'h654, a1);
        push(12'h321, 12'h098, a2);
        bus.req_valid = 1'b0;
        chk("b2b_second_accept_gap", a2 - a1, 3);
        collect(a2, 7, 28'h3210980, "b2b_second");

        // transfer in the last slot waits through one idle frame
        wait_slot(6);
        push(12'h111, 12'h222, acc);
        bus.req_valid = 1'b0;
        collect(acc, 8, 28'h1112220, "last_slot");

        // reset mid-frame with a second request buffered
        wait_slot(1);
        push(12'h246, 12'h802, a1);
        push(12'h135, 12'h791, a2);
        bus.req_valid = 1'b0;
        wait_slot(3);
        n_reset = 1'b0;
        next_cycle();
        n_reset = 1'b1;
        @(negedge clk);
        chk("rst_sample", {28'h0, sample}, 32'h0);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_frame", {31'h0, frame}, 32'h0);
        watch(3 * P - 1, nf, nd, ne);
        chk("rst_no_frames", nf, 0);
        chk("rst_no_dones", nd, 0);

        // non-BCD operand
        wait_slot(0);
        push(12'h1A3, 12'h456, acc);
        bus.req_valid = 1'b0;
`ifdef SUME_TX_BCD_CHECK_EN
        watch(2 * P, nf, nd, ne);
        chk("bcd_err_pulses", ne, 1);
        chk("bcd_no_frames", nf, 0);
`else
        collect(acc, 7, 28'h1A34560, "hex_pass");
`endif

        repeat (P) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
